// File: rtl/kb_text_ctrl.sv
// kb_text_ctrl: turns keyboard character events into character-VRAM writes
// and cursor moves for a COLS x ROWS text terminal. Keys are queued in a
// small FIFO; a CLEAR/IDLE/EXEC FSM drains them and owns the cursor.
//
// VRAM handshake: vram_req doubles as the write enable. vram_addr and
// vram_wdata are valid whenever vram_req is high and stay stable until the
// cycle in which vram_gnt is also high; that cycle completes the write.
module kb_text_ctrl #(
  parameter int         COLS       = 70,
  parameter int         ROWS       = 30,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK      = 8'h20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  ascii_code,
  input  logic [7:0]  scan_code,
  input  logic        kb_valid,
  input  logic        clr,
  input  logic        vram_gnt,
  output logic        vram_req,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  state_dbg
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX     = 5'(ROWS - 1);
  localparam logic [AW:0] CNT_FULL  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            drop;
  logic            clear_entry;
  logic            clr_pend;
  logic [7:0]      cmd;
  logic [11:0]     clr_cnt;
  logic            is_print;
  logic            is_enter;
  logic            is_bs;
  logic [6:0]      adv_x;
  logic [4:0]      adv_y;
  logic [6:0]      bs_x;
  logic [4:0]      bs_y;
  logic [4:0]      nl_y;
  logic            req_c;
  logic [11:0]     addr_c;
  logic [7:0]      wdata_c;
  logic            unused_scan;

  // The raw scan code is carried for interface uniformity only.
  assign unused_scan = ^scan_code;

  function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    return 12'(y) * 12'(COLS) + 12'(x);
  endfunction

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == CNT_FULL);
  assign clear_entry = (state == S_IDLE) && clr_pend;
  assign pop         = (state == S_IDLE) && !clr_pend && !fifo_empty;
  // Keys are ignored while clearing and on the cycle the clear begins (the FIFO is flushed then).
  assign push        = kb_valid && (state != S_CLEAR) && !clear_entry && (!fifo_full || pop);
  assign drop        = kb_valid && (state != S_CLEAR) && !clear_entry && fifo_full && !pop;

  assign is_print = (cmd >= 8'h20) && (cmd <= 8'h7E);
  assign is_enter = (cmd == 8'h0D);
  assign is_bs    = (cmd == 8'h08);

  // Candidate cursor positions for advance, newline and backspace.
  always_comb begin
    adv_x = cursor_x + 7'd1;
    adv_y = cursor_y;
    if (cursor_x == X_MAX) begin
      adv_x = 7'd0;
      adv_y = (cursor_y == Y_MAX) ? 5'd0 : cursor_y + 5'd1;
    end
    nl_y = (cursor_y == Y_MAX) ? 5'd0 : cursor_y + 5'd1;
    bs_x = cursor_x;
    bs_y = cursor_y;
    if (cursor_x != 7'd0) begin
      bs_x = cursor_x - 7'd1;
    end else if (cursor_y != 5'd0) begin
      bs_x = X_MAX;
      bs_y = cursor_y - 5'd1;
    end
  end

  // FSM state register; reset starts a full-screen clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_CLEAR;
    else       state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR: if (vram_gnt && (clr_cnt == LAST_CELL)) next_state = S_IDLE;
      S_IDLE: begin
        if (clr_pend)         next_state = S_CLEAR;
        else if (!fifo_empty) next_state = S_EXEC;
      end
      S_EXEC: if (!((is_print || is_bs) && !vram_gnt)) next_state = S_IDLE;
      default: next_state = S_CLEAR;
    endcase
  end

  // FSM outputs: the VRAM write request and its address/data.
  always_comb begin
    req_c   = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    case (state)
      S_CLEAR: begin
        req_c   = 1'b1;
        addr_c  = clr_cnt;
        wdata_c = BLANK;
      end
      S_EXEC: begin
        if (is_print) begin
          req_c   = 1'b1;
          addr_c  = cell_addr(cursor_x, cursor_y);
          wdata_c = cmd;
        end else if (is_bs) begin
          req_c   = 1'b1;
          addr_c  = cell_addr(bs_x, bs_y);
          wdata_c = BLANK;
        end
      end
      default: ;
    endcase
  end

  // The write port stays quiet while reset is asserted.
  assign vram_req   = req_c & rstn;
  assign vram_addr  = rstn ? addr_c  : '0;
  assign vram_wdata = rstn ? wdata_c : '0;
  assign busy       = (state == S_CLEAR);
  assign state_dbg  = state;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ascii_code;
  end

  // FIFO pointers, occupancy, command register and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cmd      <= '0;
      overflow <= 1'b0;
    end else if (clear_entry) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        cmd    <= fifo_mem[rd_ptr];
      end
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  // Clear request latch; a request arriving during a clear is absorbed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 clr_pend <= 1'b0;
    else if (state == S_CLEAR) clr_pend <= 1'b0;
    else if (clr)              clr_pend <= 1'b1;
  end

  // Clear address counter, stepped by each granted blank write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               clr_cnt <= '0;
    else if (clear_entry)                    clr_cnt <= '0;
    else if ((state == S_CLEAR) && vram_gnt) clr_cnt <= (clr_cnt == LAST_CELL) ? 12'd0 : clr_cnt + 12'd1;
  end

  // Cursor: homed at clear entry, moved when an EXEC command retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (clear_entry) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (state == S_EXEC) begin
      if (is_print && vram_gnt) begin
        cursor_x <= adv_x;
        cursor_y <= adv_y;
      end else if (is_bs && vram_gnt) begin
        cursor_x <= bs_x;
        cursor_y <= bs_y;
      end else if (is_enter) begin
        cursor_x <= 7'd0;
        cursor_y <= nl_y;
      end
    end
  end

endmodule

// File: tb/tb_kb_text_ctrl.sv
// Bench for kb_text_ctrl: a linear-position terminal model predicts every
// VRAM write and the cursor; a monitor matches granted writes in order.
module tb_kb_text_ctrl;

  localparam int         COLS  = 70;
  localparam int         ROWS  = 30;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic        clk;
  logic        rstn;
  logic [7:0]  ascii_code;
  logic [7:0]  scan_code;
  logic        kb_valid;
  logic        clr;
  logic        vram_gnt;
  logic        vram_req;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;
  logic        overflow;
  logic [1:0]  state_dbg;

  int          n_checks;
  int          n_fail;
  logic [19:0] exp_q[$];
  int          mx;
  int          my;
  bit          rand_gnt;

  kb_text_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .ascii_code (ascii_code),
    .scan_code  (scan_code),
    .kb_valid   (kb_valid),
    .clr        (clr),
    .vram_gnt   (vram_gnt),
    .vram_req   (vram_req),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: every granted write must be the next expected one
  always @(negedge clk) begin
    if (rstn && vram_req && vram_gnt) begin
      if (exp_q.size() == 0)
        check("write_unexpected", {12'h0, vram_addr, vram_wdata}, 32'hFFFF_FFFF);
      else
        check("write", {12'h0, vram_addr, vram_wdata}, {12'h0, exp_q.pop_front()});
    end
  end

  // reference model on a linear cell index p = y*COLS + x
  task automatic model_key(input logic [7:0] c);
    int p;
    p = my * COLS + mx;
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back({12'(p), c});
      p  = (p + 1) % CELLS;
      mx = p % COLS;
      my = p / COLS;
    end else if (c == 8'h0D) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end else if (c == 8'h08) begin
      if (p > 0) p = p - 1;
      exp_q.push_back({12'(p), BLANK});
      mx = p % COLS;
      my = p / COLS;
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < CELLS; a++) exp_q.push_back({12'(a), BLANK});
    mx = 0;
    my = 0;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_gnt) vram_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic strobe_raw(input logic [7:0] c);
    ascii_code = c;
    scan_code  = 8'($urandom_range(0, 255));
    kb_valid   = 1'b1;
    tick();
    kb_valid   = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] c);
    model_key(c);
    strobe_raw(c);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  task automatic key_done(input string tag, input logic [7:0] c);
    send_key(c);
    drain(tag, 200);
    tick();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, 32'(cursor_x), 32'(mx));
    check({tag, "_y"}, 32'(cursor_y), 32'(my));
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    logic [7:0] c;
    int         kind;
    n_checks   = 0;
    n_fail     = 0;
    mx         = 0;
    my         = 0;
    rand_gnt   = 1'b0;
    rstn       = 1'b0;
    kb_valid   = 1'b0;
    clr        = 1'b0;
    vram_gnt   = 1'b1;
    ascii_code = 8'h00;
    scan_code  = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(vram_req), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_wdata", 32'(vram_wdata), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_cur_x", 32'(cursor_x), 0);
    check("rst_cur_y", 32'(cursor_y), 0);

    // power-up clear: 2100 blank writes, then busy falls
    model_clear();
    rstn = 1'b1;
    repeat (5) tick();
    check("clear_busy_mid", 32'(busy), 1);
    drain("init_clear", CELLS + 100);
    check("clear_busy_done", 32'(busy), 0);
    check_cursor("clear_cursor");

    // 'A' at origin: cursor moves two edges after the strobe
    send_key(8'h41);
    tick();
    check("a_cur_x_edge1", 32'(cursor_x), 0);
    tick();
    check_cursor("a_edge2");
    tick();

    // walk to (69,29): Enter x29 then 69 random printables
    repeat (29) key_done("walk_nl", 8'h0D);
    check_cursor("walk_row29");
    repeat (69) key_done("walk_chr", rand_print());
    check_cursor("at_last_cell");
    key_done("z_wrap", 8'h5A);
    check_cursor("z_wrap");

    // Backspace at origin, then at (0,5)
    key_done("bs_origin", 8'h08);
    check_cursor("bs_origin");
    repeat (5) key_done("to_row5", 8'h0D);
    key_done("bs_row5", 8'h08);
    check_cursor("bs_row5");

    // Enter at (12,29): no write, cursor wraps to origin
    repeat (25) key_done("to_row29", 8'h0D);
    repeat (12) key_done("to_col12", rand_print());
    check_cursor("at_12_29");
    send_key(8'h0D);
    tick();
    check("enter_no_req", 32'(vram_req), 0);
    tick();
    tick();
    check_cursor("enter_wrap");

    // randomized keys with randomized grant
    rand_gnt = 1'b1;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      c = rand_print();
      else if (kind == 6) c = 8'h0D;
      else if (kind == 7) c = 8'h08;
      else if (kind == 8) c = 8'($urandom_range(128, 255));
      else                c = 8'h7F;
      key_done("rand", c);
      check_cursor("rand");
    end
    rand_gnt = 1'b0;
    vram_gnt = 1'b1;
    tick();

    // grant held low while 6 keys arrive: 1 executing, 4 queued, 1 lost
    check("pre_ovf", 32'(overflow), 0);
    vram_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = 8'h61 + 8'(i);
      ascii_code = c;
      kb_valid   = 1'b1;
      if (i < 5) model_key(c);
      tick();
    end
    kb_valid = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_hold_req", 32'(vram_req), 1);
      check("ovf_hold_aw", {12'h0, vram_addr, vram_wdata}, {12'h0, exp_q[0]});
      tick();
    end
    check("ovf_queued", exp_q.size(), 5);
    vram_gnt = 1'b1;
    drain("ovf_drain", 40);
    tick();
    check_cursor("ovf_cursor");
    check("ovf_sticky", 32'(overflow), 1);

    // clr while an EXEC write is stalled: write finishes, then clear
    vram_gnt = 1'b0;
    send_key(8'h51);
    repeat (3) tick();
    check("clr_hold_req", 32'(vram_req), 1);
    check("clr_hold_aw", {12'h0, vram_addr, vram_wdata}, {12'h0, exp_q[0]});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    check("clr_wait_busy", 32'(busy), 0);
    check("clr_wait_aw", {12'h0, vram_addr, vram_wdata}, {12'h0, exp_q[0]});
    model_clear();
    vram_gnt = 1'b1;
    tick();
    tick();
    check("clr_busy", 32'(busy), 1);
    check("clr_ovf_cleared", 32'(overflow), 0);
    check_cursor("clr_home");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drain("clr_clear", CELLS + 100);
    check("clr_done_busy", 32'(busy), 0);
    repeat (5) tick();
    check("clr_no_restart", 32'(busy), 0);
    check_cursor("clr_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
